// File: rtl/pc_sequencer_if.sv
// rtl/pc_sequencer_if.sv - next-PC sequencer bus bundle
//
// Purpose: groups every non-clock/reset signal of pc_sequencer.
//   slave  : the sequencer's view (control inputs in, PC write side out)
//   master : the surrounding pipeline / programCounter view
//
// Signals:
//   PCout      current PC from programCounter
//   stall      hazard stall, PC must not advance
//   br_taken   conditional branch resolved taken, target br_target
//   jmp        unconditional jump, target jmp_target
//   halt       halt instruction decoded
//   resume     leave HALT
//   exc        exception request (only honoured with PC_EXCEPTION_EN)
//   PCin       next PC to programCounter
//   PCwrite    PC write enable
//   flush      one-cycle kill of wrong-path instructions
//   halted     sequencer is in HALT
//   epc        PC saved at the last exception
interface pc_sequencer_if #(
   parameter int WIDTH = 16
);
   logic [WIDTH-1:0] PCout;
   logic             stall;
   logic             br_taken;
   logic [WIDTH-1:0] br_target;
   logic             jmp;
   logic [WIDTH-1:0] jmp_target;
   logic             halt;
   logic             resume;
   logic             exc;
   logic [WIDTH-1:0] PCin;
   logic             PCwrite;
   logic             flush;
   logic             halted;
   logic [WIDTH-1:0] epc;

   modport slave (
      input  PCout, stall, br_taken, br_target, jmp, jmp_target,
      input  halt, resume, exc,
      output PCin, PCwrite, flush, halted, epc
   );

   modport master (
      output PCout, stall, br_taken, br_target, jmp, jmp_target,
      output halt, resume, exc,
      input  PCin, PCwrite, flush, halted, epc
   );
endinterface

// File: rtl/pc_sequencer.sv
// rtl/pc_sequencer.sv - next-PC controller for the programCounter write side
//
// Purpose: each cycle selects between sequential advance, jump/branch
// redirect, hazard stall, halt and (optionally) exception vectoring.
// A redirect seen under stall is parked and replayed on the first
// unstalled cycle. Every redirect write is followed by a one-cycle flush.
//
// Ports:
//   clk   in  system clock, rising edge
//   rst   in  synchronous active-high reset
//   bus   pc_sequencer_if.slave (see rtl/pc_sequencer_if.sv)
//
// Configuration macro: PC_EXCEPTION_EN
//   defined     exc vectors to EXC_VECTOR at top priority, epc captures PCout
//   not defined exc ignored, epc tied to 0, no exception hardware built
module pc_sequencer #(
   parameter int               WIDTH        = 16,
   parameter logic [WIDTH-1:0] RESET_VECTOR = 16'h0000,
   parameter int unsigned      INC          = 2,
   parameter logic [WIDTH-1:0] EXC_VECTOR   = 16'h0040
) (
   input logic           clk,
   input logic           rst,
   pc_sequencer_if.slave bus
);

   typedef enum logic [1:0] {
      S_BOOT = 2'd0,
      S_RUN  = 2'd1,
      S_PEND = 2'd2,
      S_HALT = 2'd3
   } state_t;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] pend_q, pend_d;
   logic             flush_q;
   logic             halted_q;
   logic             redirect;
   logic [WIDTH-1:0] pcin_c;
   logic             pcwrite_c;
   logic [WIDTH-1:0] pc_inc;
   logic [WIDTH-1:0] redir_tgt;
   logic             exc_act;

   // Wraps modulo 2^WIDTH; carry is intentionally dropped.
   assign pc_inc    = bus.PCout + WIDTH'(INC);
   // Jump outranks branch when both are presented together.
   assign redir_tgt = bus.jmp ? bus.jmp_target : bus.br_target;

`ifdef PC_EXCEPTION_EN
   logic [WIDTH-1:0] epc_q;

   assign exc_act = bus.exc;

   // BOOT ignores all inputs, so the exception only lands in RUN/PEND/HALT.
   always_ff @(posedge clk) begin
      if (rst) begin
         epc_q <= '0;
      end else if (exc_act && (state_q != S_BOOT)) begin
         epc_q <= bus.PCout;
      end
   end

   assign bus.epc = epc_q;
`else
   logic unused_exc;

   assign unused_exc = bus.exc;
   assign exc_act    = 1'b0;
   assign bus.epc    = '0;
`endif

   // Next-state and PC write side
   always_comb begin
      state_d   = state_q;
      pend_d    = pend_q;
      pcin_c    = pc_inc;
      pcwrite_c = 1'b0;
      redirect  = 1'b0;

      if (rst) begin
         // Reset itself loads the vector; BOOT repeats it once more.
         pcin_c    = RESET_VECTOR;
         pcwrite_c = 1'b1;
         pend_d    = '0;
         state_d   = S_BOOT;
      end else begin
         unique case (state_q)
            S_BOOT: begin
               pcin_c    = RESET_VECTOR;
               pcwrite_c = 1'b1;
               state_d   = S_RUN;
            end

            S_RUN: begin
               if (exc_act) begin
                  pcin_c    = EXC_VECTOR;
                  pcwrite_c = 1'b1;
                  redirect  = 1'b1;
               end else if (bus.jmp || bus.br_taken) begin
                  if (bus.stall) begin
                     pend_d  = redir_tgt;
                     state_d = S_PEND;
                  end else begin
                     pcin_c    = redir_tgt;
                     pcwrite_c = 1'b1;
                     redirect  = 1'b1;
                  end
               end else if (bus.halt) begin
                  state_d = S_HALT;
               end else if (!bus.stall) begin
                  pcin_c    = pc_inc;
                  pcwrite_c = 1'b1;
               end
            end

            S_PEND: begin
               // Further jmp/br are ignored here: the parked redirect is older.
               if (exc_act) begin
                  pcin_c    = EXC_VECTOR;
                  pcwrite_c = 1'b1;
                  redirect  = 1'b1;
                  pend_d    = '0;
                  state_d   = S_RUN;
               end else if (!bus.stall) begin
                  pcin_c    = pend_q;
                  pcwrite_c = 1'b1;
                  redirect  = 1'b1;
                  pend_d    = '0;
                  state_d   = S_RUN;
               end
            end

            S_HALT: begin
               if (exc_act) begin
                  pcin_c    = EXC_VECTOR;
                  pcwrite_c = 1'b1;
                  redirect  = 1'b1;
                  state_d   = S_RUN;
               end else if (bus.resume) begin
                  pcin_c    = pc_inc;
                  pcwrite_c = 1'b1;
                  state_d   = S_RUN;
               end
            end

            default: begin
               state_d = S_BOOT;
            end
         endcase
      end
   end

   // State, pending target, flush and halted registers
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= S_BOOT;
         pend_q   <= '0;
         flush_q  <= 1'b0;
         halted_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         pend_q   <= pend_d;
         flush_q  <= redirect;
         halted_q <= (state_d == S_HALT);
      end
   end

   assign bus.PCin    = pcin_c;
   assign bus.PCwrite = pcwrite_c;
   assign bus.flush   = flush_q;
   assign bus.halted  = halted_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// tb/tb_pc_sequencer.sv - directed self-checking bench for pc_sequencer
module tb_pc_sequencer;

   logic        clk;
   logic        rst;
   logic [15:0] pc;
   logic        force_en;
   logic [15:0] force_val;
   int          n_cmp;
   int          n_err;

   pc_sequencer_if #(.WIDTH(16)) bus ();

   pc_sequencer #(
      .WIDTH       (16),
      .RESET_VECTOR(16'h0000),
      .INC         (2),
      .EXC_VECTOR  (16'h0040)
   ) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // programCounter model; force path lets the bench preload an address
   always @(posedge clk) begin
      if (force_en) pc <= force_val;
      else if (bus.PCwrite) pc <= bus.PCin;
   end
   assign bus.PCout = pc;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic idle;
      bus.stall      = 1'b0;
      bus.br_taken   = 1'b0;
      bus.br_target  = 16'h0000;
      bus.jmp        = 1'b0;
      bus.jmp_target = 16'h0000;
      bus.halt       = 1'b0;
      bus.resume     = 1'b0;
      bus.exc        = 1'b0;
   endtask

   task automatic jump_to(input logic [15:0] tgt);
      bus.jmp = 1'b1;
      bus.jmp_target = tgt;
      tick();
      bus.jmp = 1'b0;
      chk("jump_to_pc", 32'(pc), 32'(tgt));
   endtask

   initial begin
      n_cmp = 0;
      n_err = 0;
      force_en = 1'b0;
      force_val = 16'h0000;
      pc = 16'h1234;
      idle();
      rst = 1'b1;

      // Reset then free-run: 0, 0 (BOOT), 2, 4, 6
      #1;
      chk("rst_pcin", 32'(bus.PCin), 32'h0000);
      chk("rst_pcwrite", 32'(bus.PCwrite), 32'h1);
      tick();
      rst = 1'b0;
      chk("rst_pc", 32'(pc), 32'h0000);
      chk("rst_flush", 32'(bus.flush), 32'h0);
      chk("rst_halted", 32'(bus.halted), 32'h0);
      chk("rst_epc", 32'(bus.epc), 32'h0000);
      tick();
      chk("boot_pc", 32'(pc), 32'h0000);
      tick();
      chk("run_pc2", 32'(pc), 32'h0002);
      chk("run_flush2", 32'(bus.flush), 32'h0);
      tick();
      chk("run_pc4", 32'(pc), 32'h0004);
      tick();
      chk("run_pc6", 32'(pc), 32'h0006);
      chk("run_flush6", 32'(bus.flush), 32'h0);

      // Jump at PC=6 to 0x0100
      bus.jmp = 1'b1;
      bus.jmp_target = 16'h0100;
      #1;
      chk("jmp_pcin", 32'(bus.PCin), 32'h0100);
      chk("jmp_pcwrite", 32'(bus.PCwrite), 32'h1);
      tick();
      bus.jmp = 1'b0;
      chk("jmp_pc", 32'(pc), 32'h0100);
      chk("jmp_flush_hi", 32'(bus.flush), 32'h1);
      tick();
      chk("jmp_pc_next", 32'(pc), 32'h0102);
      chk("jmp_flush_lo", 32'(bus.flush), 32'h0);

      // Branch under a 3-cycle stall at PC=8; a younger jmp in PEND is ignored
      jump_to(16'h0008);
      bus.br_taken = 1'b1;
      bus.br_target = 16'h0020;
      bus.stall = 1'b1;
      #1;
      chk("brst_pcwrite", 32'(bus.PCwrite), 32'h0);
      tick();
      bus.br_taken = 1'b0;
      chk("brst_pc1", 32'(pc), 32'h0008);
      chk("brst_flush1", 32'(bus.flush), 32'h0);
      bus.jmp = 1'b1;
      bus.jmp_target = 16'h0500;
      #1;
      chk("pend_pcwrite", 32'(bus.PCwrite), 32'h0);
      tick();
      bus.jmp = 1'b0;
      chk("brst_pc2", 32'(pc), 32'h0008);
      tick();
      chk("brst_pc3", 32'(pc), 32'h0008);
      bus.stall = 1'b0;
      #1;
      chk("replay_pcin", 32'(bus.PCin), 32'h0020);
      tick();
      chk("replay_pc", 32'(pc), 32'h0020);
      chk("replay_flush", 32'(bus.flush), 32'h1);
      tick();
      chk("replay_pc_next", 32'(pc), 32'h0022);
      chk("replay_flush_lo", 32'(bus.flush), 32'h0);

      // Wrap: 0xFFFE + 2 = 0x0000
      bus.stall = 1'b1;
      force_en = 1'b1;
      force_val = 16'hFFFE;
      tick();
      force_en = 1'b0;
      bus.stall = 1'b0;
      chk("wrap_pre", 32'(pc), 32'hFFFE);
      #1;
      chk("wrap_pcin", 32'(bus.PCin), 32'h0000);
      tick();
      chk("wrap_pc", 32'(pc), 32'h0000);

      // Halt at PC=10, resume to 12 with no flush
      jump_to(16'h000A);
      bus.halt = 1'b1;
      #1;
      chk("halt_pcwrite", 32'(bus.PCwrite), 32'h0);
      tick();
      bus.halt = 1'b0;
      chk("halt_halted", 32'(bus.halted), 32'h1);
      chk("halt_pc", 32'(pc), 32'h000A);
      for (int i = 0; i < 2; i++) begin
         tick();
         chk("halt_hold_pc", 32'(pc), 32'h000A);
         chk("halt_hold_halted", 32'(bus.halted), 32'h1);
      end
      bus.resume = 1'b1;
      #1;
      chk("resume_pcin", 32'(bus.PCin), 32'h000C);
      tick();
      bus.resume = 1'b0;
      chk("resume_pc", 32'(pc), 32'h000C);
      chk("resume_halted", 32'(bus.halted), 32'h0);
      chk("resume_flush", 32'(bus.flush), 32'h0);
      tick();
      chk("resume_pc_next", 32'(pc), 32'h000E);

      // Exception at PC=0x30 while in PEND
      jump_to(16'h0030);
      bus.br_taken = 1'b1;
      bus.br_target = 16'h0200;
      bus.stall = 1'b1;
      tick();
      bus.br_taken = 1'b0;
      chk("exc_pend_pc", 32'(pc), 32'h0030);
      bus.exc = 1'b1;
      tick();
      bus.exc = 1'b0;
      bus.stall = 1'b0;
`ifdef PC_EXCEPTION_EN
      chk("exc_pc", 32'(pc), 32'h0040);
      chk("exc_epc", 32'(bus.epc), 32'h0030);
      chk("exc_flush", 32'(bus.flush), 32'h1);
      tick();
      chk("exc_pc_next", 32'(pc), 32'h0042);
      chk("exc_flush_lo", 32'(bus.flush), 32'h0);
`else
      chk("noexc_pc", 32'(pc), 32'h0030);
      chk("noexc_epc", 32'(bus.epc), 32'h0000);
      chk("noexc_flush", 32'(bus.flush), 32'h0);
      tick();
      chk("noexc_replay_pc", 32'(pc), 32'h0200);
      chk("noexc_replay_flush", 32'(bus.flush), 32'h1);
`endif

      // Reset mid-HALT discards halt state
      bus.halt = 1'b1;
      tick();
      bus.halt = 1'b0;
      chk("rsth_halted", 32'(bus.halted), 32'h1);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk("rsth_pc", 32'(pc), 32'h0000);
      chk("rsth_halted_lo", 32'(bus.halted), 32'h0);
      tick();
      tick();
      chk("rsth_run_pc", 32'(pc), 32'h0002);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
